// File: rtl/refill_rd_arbiter_pkg.sv
// Shared types and round-robin helpers for the refill read arbiter.
package refill_arb_pkg;

  localparam int unsigned MaxReq = 8;
  localparam int unsigned IdxW   = 3;

  typedef enum logic {StIdle, StLocked} arb_state_e;

  typedef struct packed {
    logic            found;
    logic [IdxW-1:0] idx;
  } rr_pick_t;

  // First set bit of eligible at or after ptr, wrapping at num_req-1.
  function automatic rr_pick_t rr_pick(input logic [MaxReq-1:0] eligible,
                                       input logic [IdxW-1:0]   ptr,
                                       input int unsigned       num_req);
    rr_pick_t    res;
    int unsigned cand;
    res = '0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= num_req) cand = cand - num_req;
      if (!res.found && (i < num_req) && eligible[cand[IdxW-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[IdxW-1:0];
      end
    end
    return res;
  endfunction

  function automatic logic [IdxW-1:0] rr_next(input logic [IdxW-1:0] idx,
                                              input int unsigned     num_req);
    return ((32'(idx) + 1) >= num_req) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/refill_rd_arbiter_if.sv
// Read-request / read-beat bus between the refill arbiter and the AXI shim.
interface refill_rd_arbiter_if #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned BlenWidth = 2
);
  logic                 rd_req;
  logic                 rd_gnt;
  logic [AddrWidth-1:0] rd_addr;
  logic [BlenWidth-1:0] rd_blen;
  logic [2:0]           rd_size;
  logic [IdWidth-1:0]   rd_id;
  logic                 rd_valid;
  logic                 rd_last;
  logic [DataWidth-1:0] rd_data;
  logic [IdWidth-1:0]   rd_rid;

  modport master (
    output rd_req, rd_addr, rd_blen, rd_size, rd_id,
    input  rd_gnt, rd_valid, rd_last, rd_data, rd_rid
  );

  modport slave (
    input  rd_req, rd_addr, rd_blen, rd_size, rd_id,
    output rd_gnt, rd_valid, rd_last, rd_data, rd_rid
  );
endinterface

// File: rtl/refill_rr_arbiter.sv
// Round-robin picker: eligible vector plus priority pointer to one-hot grant.
module refill_rr_arbiter
  import refill_arb_pkg::*;
#(
  parameter int unsigned NumReq = 2
) (
  input  logic [NumReq-1:0] eligible_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              found_o
);
  rr_pick_t w_pick;

  assign w_pick  = rr_pick(MaxReq'(eligible_i), ptr_i, NumReq);
  assign idx_o   = w_pick.idx;
  assign found_o = w_pick.found;

  always_comb begin
    gnt_o = '0;
    for (int n = 0; n < NumReq; n++) begin
      gnt_o[n] = w_pick.found && (w_pick.idx == IdxW'(n));
    end
  end
endmodule

// File: rtl/refill_rd_arbiter.sv
// Shares one AXI-shim read-request port among refill requesters and routes beats back by ID.
module refill_rd_arbiter
  import refill_arb_pkg::*;
#(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned BlenWidth = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumReq-1:0]           req_valid_i,
  output logic [NumReq-1:0]           req_ready_o,
  input  logic [NumReq*AddrWidth-1:0] req_addr_i,
  input  logic [NumReq*BlenWidth-1:0] req_blen_i,
  output logic [NumReq-1:0]           rsp_valid_o,
  output logic                        rsp_last_o,
  output logic [DataWidth-1:0]        rsp_data_o,
  output logic                        busy_o,
  output logic                        err_o,
  refill_rd_arbiter_if.master         shim
);
  arb_state_e           r_state;
  logic [IdxW-1:0]      r_rr_ptr;
  logic [IdxW-1:0]      r_lock_idx;
  logic [AddrWidth-1:0] r_lock_addr;
  logic [BlenWidth-1:0] r_lock_blen;
  logic [NumReq-1:0]    r_outstanding;

  logic [NumReq-1:0]    w_eligible, w_pick_gnt, w_lock_gnt, w_sel_gnt;
  logic [NumReq-1:0]    w_hit, w_set, w_clr;
  logic [IdxW-1:0]      w_pick_idx, w_sel_idx;
  logic                 w_pick_found, w_lock, w_req, w_fire;
  logic [AddrWidth-1:0] w_pick_addr, w_sel_addr;
  logic [BlenWidth-1:0] w_pick_blen, w_sel_blen;

  assign w_eligible = req_valid_i & ~r_outstanding;

  refill_rr_arbiter #(
    .NumReq (NumReq)
  ) u_rr (
    .eligible_i (w_eligible),
    .ptr_i      (r_rr_ptr),
    .gnt_o      (w_pick_gnt),
    .idx_o      (w_pick_idx),
    .found_o    (w_pick_found)
  );

  always_comb begin
    w_pick_addr = '0;
    w_pick_blen = '0;
    w_lock_gnt  = '0;
    for (int n = 0; n < NumReq; n++) begin
      if (w_pick_idx == IdxW'(n)) begin
        w_pick_addr = req_addr_i[n*AddrWidth +: AddrWidth];
        w_pick_blen = req_blen_i[n*BlenWidth +: BlenWidth];
      end
      w_lock_gnt[n] = (r_lock_idx == IdxW'(n));
    end
  end

  // While locked the latched request is replayed unchanged, whatever req_valid_i does.
  assign w_lock     = (r_state == StLocked);
  assign w_req      = ~rst_i & (w_lock | w_pick_found);
  assign w_sel_idx  = w_lock ? r_lock_idx  : w_pick_idx;
  assign w_sel_addr = w_lock ? r_lock_addr : w_pick_addr;
  assign w_sel_blen = w_lock ? r_lock_blen : w_pick_blen;
  assign w_sel_gnt  = w_lock ? w_lock_gnt  : w_pick_gnt;
  assign w_fire     = w_req & shim.rd_gnt;

  assign shim.rd_req  = w_req;
  assign shim.rd_addr = w_req ? w_sel_addr : '0;
  assign shim.rd_blen = w_req ? w_sel_blen : '0;
  assign shim.rd_id   = w_req ? IdWidth'(w_sel_idx) : '0;
  assign shim.rd_size = 3'($clog2(DataWidth / 8));
  assign req_ready_o  = w_fire ? w_sel_gnt : '0;

  always_comb begin
    w_hit = '0;
    for (int n = 0; n < NumReq; n++) begin
      w_hit[n] = (shim.rd_rid == IdWidth'(n)) & r_outstanding[n];
    end
  end

  assign rsp_valid_o = shim.rd_valid ? w_hit : '0;
  assign err_o       = shim.rd_valid & ~(|w_hit);
  assign rsp_data_o  = shim.rd_data;
  assign rsp_last_o  = shim.rd_last;
  assign busy_o      = w_lock | (|r_outstanding);

  assign w_clr = (shim.rd_valid & shim.rd_last) ? w_hit : '0;
  assign w_set = w_fire ? w_sel_gnt : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= StIdle;
      r_rr_ptr      <= '0;
      r_lock_idx    <= '0;
      r_lock_addr   <= '0;
      r_lock_blen   <= '0;
      r_outstanding <= '0;
    end else begin
      r_outstanding <= (r_outstanding & ~w_clr) | w_set;
      case (r_state)
        StIdle: begin
          if (w_pick_found) begin
            if (shim.rd_gnt) begin
              r_rr_ptr <= rr_next(w_pick_idx, NumReq);
            end else begin
              r_state     <= StLocked;
              r_lock_idx  <= w_pick_idx;
              r_lock_addr <= w_pick_addr;
              r_lock_blen <= w_pick_blen;
            end
          end
        end
        StLocked: begin
          if (shim.rd_gnt) begin
            r_rr_ptr <= rr_next(r_lock_idx, NumReq);
            r_state  <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  a_hold_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (shim.rd_req && !shim.rd_gnt) |=>
      ($stable(shim.rd_addr) && $stable(shim.rd_blen) && $stable(shim.rd_id)));
  a_ready_onehot: assert property (@(posedge clk_i) $onehot0(req_ready_o));
  a_rsp_onehot: assert property (@(posedge clk_i) $onehot0(rsp_valid_o));

endmodule

// File: tb/tb_refill_rd_arbiter.sv
// Directed and randomized checks of refill_rd_arbiter against a cycle-level reference model.
module tb_refill_rd_arbiter;
  localparam int unsigned NR = 2;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned IW = 4;
  localparam int unsigned BW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid, req_ready, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*BW-1:0] req_blen;
  logic            rsp_last, busy, err;
  logic [DW-1:0]   rsp_data;

  refill_rd_arbiter_if #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .BlenWidth(BW)) shim ();

  refill_rd_arbiter #(
    .NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .BlenWidth(BW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_blen_i  (req_blen),
    .rsp_valid_o (rsp_valid),
    .rsp_last_o  (rsp_last),
    .rsp_data_o  (rsp_data),
    .busy_o      (busy),
    .err_o       (err),
    .shim        (shim)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: which requesters own a burst, the request held for the shim, RR priority.
  logic [NR-1:0] m_out;
  bit            m_lock;
  int            m_lk_idx;
  logic [AW-1:0] m_lk_addr;
  logic [BW-1:0] m_lk_blen;
  int            m_ptr;
  int            fly_rem[NR];
  bit            f_fire;
  int            f_idx;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int n, input bit v, input logic [AW-1:0] a, input logic [BW-1:0] b);
    req_valid[n]         = v;
    req_addr[n*AW +: AW] = a;
    req_blen[n*BW +: BW] = b;
  endtask

  task automatic beat(input bit v, input int id, input bit last, input logic [DW-1:0] d);
    shim.rd_valid = v;
    shim.rd_rid   = IW'(id);
    shim.rd_last  = last;
    shim.rd_data  = d;
  endtask

  task automatic tick();
    bit            e_req;
    int            e_idx;
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_blen;
    bit            hit;
    int            n;
    int            rid;
    e_req = 0; e_idx = 0; e_addr = '0; e_blen = '0; hit = 0;
    @(negedge clk);
    if (!rst) begin
      if (m_lock) begin
        e_req = 1; e_idx = m_lk_idx; e_addr = m_lk_addr; e_blen = m_lk_blen;
      end else begin
        for (int k = 0; k < NR; k++) begin
          n = (m_ptr + k) % NR;
          if (!e_req && req_valid[n] && !m_out[n]) begin
            e_req = 1; e_idx = n;
            e_addr = req_addr[n*AW +: AW];
            e_blen = req_blen[n*BW +: BW];
          end
        end
      end
      check("rd_req", 64'(shim.rd_req), 64'(e_req));
      if (e_req) begin
        check("rd_id", 64'(shim.rd_id), 64'(e_idx));
        check("rd_addr", shim.rd_addr, e_addr);
        check("rd_blen", 64'(shim.rd_blen), 64'(e_blen));
      end
      check("req_ready", 64'(req_ready), (e_req && shim.rd_gnt) ? 64'(1) << e_idx : 64'(0));
      rid = int'(shim.rd_rid);
      hit = shim.rd_valid && (rid < NR) && m_out[rid % NR];
      check("rsp_valid", 64'(rsp_valid), hit ? 64'(1) << rid : 64'(0));
      check("err", 64'(err), 64'(shim.rd_valid && !hit));
      if (hit) begin
        check("rsp_last", 64'(rsp_last), 64'(shim.rd_last));
        check("rsp_data", rsp_data, shim.rd_data);
      end
      check("busy", 64'(busy), 64'(m_lock || (|m_out)));
    end
    @(posedge clk);
    f_fire = 0;
    if (rst) begin
      m_out = '0; m_lock = 0; m_ptr = 0;
      for (int k = 0; k < NR; k++) fly_rem[k] = 0;
    end else begin
      rid = int'(shim.rd_rid);
      if (shim.rd_valid && rid < NR) begin
        if (shim.rd_last) m_out[rid] = 1'b0;
        if (fly_rem[rid] > 0) fly_rem[rid]--;
      end
      if (e_req && shim.rd_gnt) begin
        m_out[e_idx] = 1'b1;
        m_ptr = (e_idx + 1) % NR;
        m_lock = 0;
        f_fire = 1; f_idx = e_idx;
        fly_rem[e_idx] = int'(e_blen) + 1;
      end else if (e_req && !m_lock) begin
        m_lock = 1; m_lk_idx = e_idx; m_lk_addr = e_addr; m_lk_blen = e_blen;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    shim.rd_gnt = 1'b0;
    beat(0, 0, 0, '0);
    tick();
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    #1;
    check({tag, "_rd_req"}, 64'(shim.rd_req), 64'(0));
    check({tag, "_ready"}, 64'(req_ready), 64'(0));
    check({tag, "_rsp"}, 64'(rsp_valid), 64'(0));
    check({tag, "_err"}, 64'(err), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_addr"}, shim.rd_addr, 64'(0));
    check({tag, "_id"}, 64'(shim.rd_id), 64'(0));
  endtask

  initial begin
    logic [AW-1:0] a0, a1, ra;
    int            r, id;
    req_valid = '0; req_addr = '0; req_blen = '0;
    shim.rd_gnt = 1'b0;
    beat(0, 0, 0, '0);
    m_out = '0; m_lock = 0; m_ptr = 0; f_fire = 0; f_idx = 0;
    for (int k = 0; k < NR; k++) fly_rem[k] = 0;

    do_reset();
    check_all_zero("reset");
    check("rd_size", 64'(shim.rd_size), 64'(3));

    // Single request granted in its own cycle, then a four-beat burst.
    set_req(0, 1, 64'h8000_0040, 2'd3);
    shim.rd_gnt = 1'b1;
    tick();
    check("t1_fire", 64'(f_fire), 64'(1));
    check("t1_idx", 64'(f_idx), 64'(0));
    req_valid = '0; shim.rd_gnt = 1'b0;
    for (int b = 0; b < 4; b++) begin
      beat(1, 0, b == 3, 64'(b) + 64'hA5A5_0000);
      #1;
      check("t1_rsp", 64'(rsp_valid), 64'(1));
      check("t1_last", 64'(rsp_last), 64'(b == 3));
      tick();
    end
    beat(0, 0, 0, '0);
    #1;
    check("t1_idle", 64'(busy), 64'(0));

    // Grant withheld five cycles: req0 stays on the bus even after it drops valid.
    do_reset();
    a0 = 64'h0000_1000_0000_0080;
    a1 = 64'h0000_2000_0000_00C0;
    set_req(0, 1, a0, 2'd1);
    set_req(1, 1, a1, 2'd2);
    for (int c = 0; c < 6; c++) begin
      if (c == 2) req_valid[0] = 1'b0;
      if (c == 5) shim.rd_gnt = 1'b1;
      #1;
      check("t2_frozen_addr", shim.rd_addr, a0);
      check("t2_frozen_id", 64'(shim.rd_id), 64'(0));
      tick();
    end
    check("t2_fire0", 64'(f_fire && f_idx == 0), 64'(1));
    #1;
    check("t2_next_id", 64'(shim.rd_id), 64'(1));
    check("t2_next_addr", shim.rd_addr, a1);
    tick();
    check("t2_fire1", 64'(f_fire && f_idx == 1), 64'(1));

    // Both always valid with one-beat bursts: grants must alternate.
    do_reset();
    set_req(0, 1, 64'h100, 2'd0);
    set_req(1, 1, 64'h200, 2'd0);
    shim.rd_gnt = 1'b1;
    id = -1;
    for (int c = 0; c < 10; c++) begin
      if (id >= 0) beat(1, id, 1, 64'(c));
      else beat(0, 0, 0, '0);
      tick();
      check("t3_rr", 64'(f_fire ? f_idx : -1), 64'(c % 2));
      id = f_fire ? f_idx : -1;
    end

    // Re-request while outstanding is held off until the cycle after the last beat.
    do_reset();
    set_req(0, 1, 64'h300, 2'd1);
    shim.rd_gnt = 1'b1;
    beat(0, 0, 0, '0);
    tick();
    #1;
    check("t4_block_a", 64'(shim.rd_req), 64'(0));
    tick();
    beat(1, 0, 0, 64'h11);
    #1;
    check("t4_block_b", 64'(shim.rd_req), 64'(0));
    tick();
    beat(1, 0, 1, 64'h22);
    #1;
    check("t4_block_last", 64'(shim.rd_req), 64'(0));
    tick();
    beat(0, 0, 0, '0);
    #1;
    check("t4_resume", 64'(shim.rd_req && shim.rd_id == 0), 64'(1));
    tick();
    req_valid = '0; shim.rd_gnt = 1'b0;

    // Beats with an out-of-range ID or a non-outstanding ID are dropped.
    do_reset();
    beat(1, 3, 1, 64'hDEAD);
    #1;
    check("t5_err_id3", 64'(err), 64'(1));
    check("t5_rsp_id3", 64'(rsp_valid), 64'(0));
    tick();
    beat(1, 1, 0, 64'hBEEF);
    #1;
    check("t5_err_id1", 64'(err), 64'(1));
    check("t5_rsp_id1", 64'(rsp_valid), 64'(0));
    tick();
    beat(0, 0, 0, '0);
    #1;
    check("t5_quiet", 64'(err), 64'(0));

    // Reset during a locked wait and mid-burst.
    do_reset();
    set_req(1, 1, 64'h400, 2'd3);
    shim.rd_gnt = 1'b1;
    tick();
    req_valid[1] = 1'b0;
    set_req(0, 1, 64'h500, 2'd0);
    shim.rd_gnt = 1'b0;
    tick();
    beat(1, 1, 0, 64'h33);
    tick();
    do_reset();
    check_all_zero("t6_post_rst");
    beat(1, 1, 0, 64'h44);
    #1;
    check("t6_left_err", 64'(err), 64'(1));
    check("t6_left_rsp", 64'(rsp_valid), 64'(0));
    tick();
    beat(0, 0, 0, '0);
    set_req(1, 1, 64'h600, 2'd0);
    shim.rd_gnt = 1'b1;
    #1;
    check("t6_resume_id", 64'(shim.rd_req && shim.rd_id == 1), 64'(1));
    tick();
    check("t6_resume_fire", 64'(f_fire && f_idx == 1), 64'(1));

    // Randomized traffic, interleaved beats and stray IDs.
    do_reset();
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int n = 0; n < NR; n++) begin
        if (!req_valid[n] && $urandom_range(0, 3) == 0) begin
          ra = {$urandom, $urandom};
          set_req(n, 1, ra, BW'($urandom_range(0, 3)));
        end
      end
      shim.rd_gnt = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 5);
      if (r < NR && fly_rem[r] > 0) begin
        beat(1, r, fly_rem[r] == 1, {$urandom, $urandom});
      end else if (r == 5) begin
        id = $urandom_range(0, 15);
        if (id < NR && fly_rem[id] > 0) beat(0, 0, 0, '0);
        else beat(1, id, $urandom_range(0, 1) == 1, {$urandom, $urandom});
      end else begin
        beat(0, 0, 0, '0);
      end
      tick();
      if (f_fire) req_valid[f_idx] = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
